// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - funct codes of the eight muldiv instructions
//   - FSM state type
//   - ALU funct list (pass-through, neither handled nor flagged illegal)
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam int N_ALU = 7;
    localparam logic [5:0] ALU_FUNCTS [0:N_ALU-1] = '{
        6'b100000, 6'b100010, 6'b100100, 6'b100101,
        6'b101010, 6'b000000, 6'b000010
    };

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic is_muldiv_funct(input logic [5:0] f);
        case (f)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: is_muldiv_funct = 1'b1;
            default:                        is_muldiv_funct = 1'b0;
        endcase
    endfunction

    function automatic logic is_alu_funct(input logic [5:0] f);
        is_alu_funct = 1'b0;
        for (int i = 0; i < N_ALU; i++) begin
            if (f == ALU_FUNCTS[i]) is_alu_funct = 1'b1;
        end
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: unsigned radix-2 datapath, one bit per i_step.
//   Multiply: shift/add, product = {o_hi, o_lo}.
//   Divide:   restoring shift/subtract, remainder = o_hi, quotient = o_lo.
// Ports:
//   clk, reset   clock, async active-low reset
//   i_load       capture operands and mode (i_div) for a new operation
//   i_step       process one bit
//   i_a, i_b     unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   o_hi, o_lo   accumulator and partial register
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic             r_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_opb;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_part[0] ? {1'b0, r_opb} : '0);
        w_shift = {r_acc, r_part[WIDTH-1]};
        // Two guard bits: the shifted remainder can reach 2^WIDTH, so a
        // single extra bit would not be a reliable borrow.
        w_diff  = {1'b0, w_shift} - {2'b00, r_opb};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= 1'b0;
            r_acc  <= '0;
            r_part <= '0;
            r_opb  <= '0;
        end else if (i_load) begin
            r_div  <= i_div;
            r_acc  <= '0;
            r_part <= i_div ? i_a : i_b;
            r_opb  <= i_div ? i_b : i_a;
        end else if (i_step) begin
            if (r_div) begin
                if (!w_diff[WIDTH+1]) begin
                    r_acc  <= w_diff[WIDTH-1:0];
                    r_part <= {r_part[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc  <= w_shift[WIDTH-1:0];
                    r_part <= {r_part[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc  <= w_sum[WIDTH:1];
                r_part <= {w_sum[0], r_part[WIDTH-1:1]};
            end
        end
    end

    assign o_hi = r_acc;
    assign o_lo = r_part;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset     clock, async active-low reset
//   start, flush   valid R-type in EX; squash in-flight op
//   funct, a, b    instruction funct, rs and rt operands
//   busy, stall    op in flight; combinational pipeline freeze
//   done           pulse after HI/LO written by MULT/DIV
//   result         HI for MFHI, LO for MFLO, else 0
//   illegal        pulse after start with an unrecognised funct
//
// state | meaning
// IDLE  | accepts new instructions, MTHI/MTLO write, MFHI/MFLO read
// MUL   | shift/add, one multiplier bit per cycle
// DIV   | shift/subtract, one quotient bit per cycle
// FIX   | sign correction, HI/LO write, done
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_is_div, r_neg_q, r_neg_r, r_div0;
    logic             r_done, r_illegal;

    logic             w_accept, w_mul_op, w_div_op, w_signed_op, w_load, w_step;
    logic             w_sa, w_sb;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH-1:0] w_iter_hi, w_iter_lo, w_fix_hi, w_fix_lo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept    = start && !flush && (r_state == IDLE);
    assign w_mul_op    = (funct == F_MULT) || (funct == F_MULTU);
    assign w_div_op    = (funct == F_DIV)  || (funct == F_DIVU);
    assign w_signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign w_load      = w_accept && (w_mul_op || w_div_op);
    assign w_step      = (r_state == MUL) || (r_state == DIV);

    assign w_sa    = w_signed_op && a[WIDTH-1];
    assign w_sb    = w_signed_op && b[WIDTH-1];
    assign w_abs_a = w_sa ? -a : a;
    assign w_abs_b = w_sb ? -b : b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_mul_op)      w_state_nxt = MUL;
                else if (w_accept && w_div_op) w_state_nxt = DIV;
            end
            MUL, DIV: if (r_cnt == CW'(1)) w_state_nxt = FIX;
            FIX:      w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (flush) begin
            r_cnt    <= '0;
        end else if (w_load) begin
            r_cnt    <= CW'(WIDTH);
            r_is_div <= w_div_op;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_div0   <= (b == '0);
        end else if (w_step) begin
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_div  (w_div_op),
        .i_a    (w_abs_a),
        .i_b    (w_abs_b),
        .o_hi   (w_iter_hi),
        .o_lo   (w_iter_lo)
    );

    // Divide by zero yields an all-ones quotient and remainder = |a| from the
    // datapath; forcing LO and re-applying sign(a) to HI gives LO=~0, HI=a.
    always_comb begin
        w_prod = {w_iter_hi, w_iter_lo};
        if (r_neg_q) w_prod = -{w_iter_hi, w_iter_lo};
        if (r_is_div) begin
            w_fix_lo = r_div0 ? '1 : (r_neg_q ? -w_iter_lo : w_iter_lo);
            w_fix_hi = r_neg_r ? -w_iter_hi : w_iter_hi;
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == FIX) && !flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if (w_accept && (funct == F_MTHI)) begin
            r_hi <= a;
        end else if (w_accept && (funct == F_MTLO)) begin
            r_lo <= a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= (r_state == FIX) && !flush;
            r_illegal <= start && !flush && !is_muldiv_funct(funct) && !is_alu_funct(funct);
        end
    end

    assign busy    = (r_state != IDLE);
    assign stall   = start && busy && is_muldiv_funct(funct);
    assign done    = r_done;
    assign illegal = r_illegal;

    always_comb begin
        case (funct)
            F_MFHI:  result = r_hi;
            F_MFLO:  result = r_lo;
            default: result = '0;
        endcase
    end

endmodule
